// File: rtl/alarm_ringer_if.sv
// rtl/alarm_ringer_if.sv - alarm ringer control/status signal bundle
interface alarm_ringer_if;
    logic       alarmLight;
    logic       snoozeButton;
    logic       stopButton;
    logic [7:0] curHour;
    logic [7:0] curMin;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic       missed;
    logic [1:0] snoozeCount;

    modport master (
        output alarmLight, snoozeButton, stopButton, curHour, curMin,
        input  buzzer, ringing, snoozing, missed, snoozeCount
    );

    modport slave (
        input  alarmLight, snoozeButton, stopButton, curHour, curMin,
        output buzzer, ringing, snoozing, missed, snoozeCount
    );
endinterface

// File: rtl/alarm_ringer.sv
// rtl/alarm_ringer.sv - alarm ring/snooze/dismiss sequencer with gated buzzer tone
module alarm_ringer #(
    parameter int TONE_DIV   = 2,
    parameter int BEEP_DIV   = 16,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic          clk,
    input  logic          reset,
    alarm_ringer_if.slave bus
);
    localparam int TW = $clog2(TONE_DIV + 1);
    localparam int BW = $clog2(BEEP_DIV + 1);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE, DONE} state_t;

    state_t        state_q, state_d;
    logic          alarm_prev_q, snooze_prev_q, stop_prev_q, armed_q;
    logic [7:0]    ring_min_q, ring_min_d;
    logic [7:0]    tgt_hour_q, tgt_hour_d, tgt_min_q, tgt_min_d;
    logic [1:0]    count_q, count_d;
    logic          missed_q, missed_d;
    logic          ring_entry;
    logic [TW-1:0] tone_cnt_q;
    logic [BW-1:0] beep_cnt_q;
    logic          tone_q, gate_q;

    logic alarm_rise, snooze_rise, stop_rise;
    // armed_q blocks an alarm level still high from before reset until it has been seen low
    assign alarm_rise  = bus.alarmLight & ~alarm_prev_q & armed_q;
    assign snooze_rise = bus.snoozeButton & ~snooze_prev_q;
    assign stop_rise   = bus.stopButton & ~stop_prev_q;

    logic [4:0] unit_sum;
    logic       unit_carry, hour_inc;
    logic [3:0] sum_units, sum_tens;
    logic [7:0] sum_hour;

    always_comb begin
        unit_sum   = {1'b0, bus.curMin[3:0]} + 5'(SNOOZE_MIN);
        unit_carry = (unit_sum >= 5'd10);
        sum_units  = unit_carry ? 4'(unit_sum - 5'd10) : unit_sum[3:0];
        sum_tens   = bus.curMin[7:4] + {3'b000, unit_carry};
        hour_inc   = 1'b0;
        if (sum_tens == 4'd6) begin
            sum_tens = 4'd0;
            hour_inc = 1'b1;
        end
        sum_hour = bus.curHour;
        if (hour_inc) begin
            if (bus.curHour == 8'h23)
                sum_hour = 8'h00;
            else if (bus.curHour[3:0] == 4'd9)
                sum_hour = {bus.curHour[7:4] + 4'd1, 4'h0};
            else
                sum_hour = bus.curHour + 8'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        ring_min_d = ring_min_q;
        tgt_hour_d = tgt_hour_q;
        tgt_min_d  = tgt_min_q;
        count_d    = count_q;
        missed_d   = missed_q;
        ring_entry = 1'b0;
        case (state_q)
            IDLE: if (alarm_rise) begin
                state_d    = RING;
                missed_d   = 1'b0;
                count_d    = 2'd0;
                ring_min_d = bus.curMin;
                ring_entry = 1'b1;
            end
            RING: begin
                if (stop_rise) begin
                    state_d = DONE;
                end else if (snooze_rise) begin
                    if (count_q < 2'(MAX_SNOOZE)) begin
                        state_d    = SNOOZE;
                        count_d    = count_q + 2'd1;
                        tgt_hour_d = sum_hour;
                        tgt_min_d  = {sum_tens, sum_units};
                    end
                end else if (bus.curMin != ring_min_q) begin
                    state_d  = IDLE;
                    missed_d = 1'b1;
                end
            end
            SNOOZE: begin
                if (stop_rise) begin
                    state_d = IDLE;
                    count_d = 2'd0;
                end else if (bus.curHour == tgt_hour_q && bus.curMin == tgt_min_q) begin
                    state_d    = RING;
                    ring_min_d = bus.curMin;
                    ring_entry = 1'b1;
                end
            end
            DONE: if (!bus.alarmLight) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            alarm_prev_q  <= 1'b0;
            snooze_prev_q <= 1'b0;
            stop_prev_q   <= 1'b0;
            armed_q       <= 1'b0;
            ring_min_q    <= 8'h00;
            tgt_hour_q    <= 8'h00;
            tgt_min_q     <= 8'h00;
            count_q       <= 2'd0;
            missed_q      <= 1'b0;
            tone_cnt_q    <= '0;
            beep_cnt_q    <= '0;
            tone_q        <= 1'b0;
            gate_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            alarm_prev_q  <= bus.alarmLight;
            snooze_prev_q <= bus.snoozeButton;
            stop_prev_q   <= bus.stopButton;
            armed_q       <= armed_q | ~bus.alarmLight;
            ring_min_q    <= ring_min_d;
            tgt_hour_q    <= tgt_hour_d;
            tgt_min_q     <= tgt_min_d;
            count_q       <= count_d;
            missed_q      <= missed_d;
            if (ring_entry) begin
                tone_cnt_q <= '0;
                beep_cnt_q <= '0;
                tone_q     <= 1'b1;
                gate_q     <= 1'b1;
            end else if (state_q == RING) begin
                if (tone_cnt_q == TW'(TONE_DIV - 1)) begin
                    tone_cnt_q <= '0;
                    tone_q     <= ~tone_q;
                end else begin
                    tone_cnt_q <= tone_cnt_q + TW'(1);
                end
                if (beep_cnt_q == BW'(BEEP_DIV - 1)) begin
                    beep_cnt_q <= '0;
                    gate_q     <= ~gate_q;
                end else begin
                    beep_cnt_q <= beep_cnt_q + BW'(1);
                end
            end
        end
    end

    assign bus.ringing     = (state_q == RING);
    assign bus.snoozing    = (state_q == SNOOZE);
    assign bus.buzzer      = bus.ringing & tone_q & gate_q;
    assign bus.missed      = missed_q;
    assign bus.snoozeCount = count_q;
endmodule

// File: doc/alarm_ringer.md
ALARM_RINGER -- requirements
Module: alarm_ringer

Interface
REQ-001 Parameter TONE_DIV, default 2: clk cycles per buzzer tone half-period.
REQ-002 Parameter BEEP_DIV, default 16: clk cycles per beep-gate half-period (on/off cadence).
REQ-003 Parameter SNOOZE_MIN, default 5: snooze length in minutes, range 1-9.
REQ-004 Parameter MAX_SNOOZE, default 3: snoozes allowed per alarm event.
REQ-005 clk  in  1  system clock, all logic on posedge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 alarmLight  in  1  alarm match level from the alarm block (high for the matching minute).
REQ-008 snoozeButton  in  1  snooze request, level, debounced upstream.
REQ-009 stopButton  in  1  dismiss request, level, debounced upstream.
REQ-010 curHour  in  8  current hour, BCD 00-23.
REQ-011 curMin  in  8  current minute, BCD 00-59.
REQ-012 buzzer  out  1  gated square-wave tone to the speaker.
REQ-013 ringing  out  1  high in RING.
REQ-014 snoozing  out  1  high in SNOOZE.
REQ-015 missed  out  1  sticky flag: an alarm event ended with no user action.
REQ-016 snoozeCount  out  2  snoozes taken in the current event.

Function
REQ-017 Buttons and alarmLight SHALL be rising-edge detected internally via one registered copy each; only the rising edge acts.
REQ-018 States SHALL be IDLE, RING, SNOOZE, DONE.
REQ-019 IDLE -> RING on alarmLight rising edge; missed and snoozeCount cleared; curMin captured as ringMin.
REQ-020 RING + stop edge -> DONE.
REQ-021 RING + snooze edge with snoozeCount < MAX_SNOOZE -> SNOOZE; snoozeCount +1; target = curHour:curMin + SNOOZE_MIN minutes.
REQ-022 RING + snooze edge with snoozeCount == MAX_SNOOZE: ignored, stay RING.
REQ-023 Stop and snooze edges in the same cycle: stop wins.
REQ-024 RING with curMin != ringMin and no button edge that cycle -> IDLE, missed = 1.
REQ-025 SNOOZE + stop edge -> IDLE, snoozeCount cleared.
REQ-026 SNOOZE with curHour == targetHour and curMin == targetMin -> RING; ringMin recaptured.
REQ-027 DONE -> IDLE once alarmLight is low; DONE never re-rings in the same matching minute.
REQ-028 Target arithmetic SHALL be BCD: minute units carry at 9, tens wrap at 5 with hour increment; hour 23 wraps to 00 (23:57 + 5 = 00:02).
REQ-029 Transitions SHALL take effect one cycle after the qualifying edge is sampled; ringing/snoozing are registered state decodes.
REQ-030 Tone and beep counters SHALL clear on every RING entry; buzzer = tone AND beepGate, both starting high on entry.
REQ-031 buzzer SHALL be 0 in every state other than RING.
REQ-032 missed SHALL stay 1 until the next IDLE -> RING transition or reset.

Reset
REQ-033 reset low at a clock edge SHALL force IDLE, all outputs 0, counters, edge registers, ringMin and target to 0.
REQ-034 Reset mid-RING or mid-SNOOZE SHALL silence buzzer the following cycle; an alarmLight already high at release SHALL NOT trigger until it falls and rises again.

Verification
REQ-035 alarmLight rises at 07:30 -> ringing = 1 next cycle; buzzer toggles every 2 cycles, silent for 16-cycle windows every 32 cycles.
REQ-036 Ringing at 07:30, snooze edge -> snoozing = 1, snoozeCount = 1; curMin to 0x35 -> ringing = 1 again.
REQ-037 Ringing at 23:57, snooze -> target 00:02; ring re-enters at curHour 0x00, curMin 0x02.
REQ-038 Ringing, curMin 0x30 -> 0x31 with no button -> IDLE, missed = 1, buzzer 0; next alarmLight rise clears missed.
REQ-039 Three snoozes taken, fourth snooze edge -> stays RING, snoozeCount = 3; stop and snooze same cycle -> DONE, stays DONE until alarmLight low.
REQ-040 reset low during RING -> all outputs 0 next cycle; alarmLight held high through release -> no ring.
